dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port, byte-write-enable data RAM between two requesters: the core load/store path and a debug/loader port. It grants one access per cycle and converts core byte/half/word accesses into lane enables and replicated write data. It also aligns and sign/zero-extends read data one cycle later and flags misaligned core accesses. It sits between the MemoryAccess stage and the data RAM instance.

## Interface
- AWIDTH, from core_general.vh: RAM word-address width.
- DWIDTH, 32: data width; only 32 is supported.
- STARVE_MAX, 4: consecutive contested core wins before the debug port is forced a slot (1..15).

Ports:
- clk  in  1  global clock
- rst  in  1  synchronous, active-high reset
- c_req  in  1  core access request
- c_wr  in  1  1 = store, 0 = load
- c_addr  in  AWIDTH+2  core byte address
- c_size  in  2  access size: 00 byte, 01 half, 10 word
- c_uns  in  1  load zero-extend (1) or sign-extend (0)
- c_wdata  in  32  store data, right-justified
- c_gnt  out  1  request accepted this cycle
- c_misalign  out  1  misaligned request rejected this cycle
- c_rvalid  out  1  load data valid
- c_rdata  out  32  aligned, extended load data
- d_req  in  1  debug access request
- d_we  in  4  byte strobes; 0000 = read
- d_addr  in  AWIDTH  debug word address
- d_wdata  in  32  debug write data
- d_gnt  out  1  debug request accepted
- d_rvalid  out  1  debug read data valid
- d_rdata  out  32  raw RAM word
- ram_addr  out  AWIDTH  to RAM addr
- ram_qin  out  32  to RAM qin
- ram_we  out  4  to RAM we
- ram_qout  in  32  from RAM qout (registered, read-first)

## Operation
Arbitration, evaluated combinationally in cycle T:
- Only one requester active: that requester is granted.
- Both active: core wins unless starve_cnt == STARVE_MAX, in which case debug wins.
- starve_cnt increments on each cycle where both request and core wins. It clears to 0 on any debug grant and on any cycle where d_req is low.

Core byte lanes, little-endian, off = c_addr[1:0]:
- Byte: ram_we = 0001 << off; ram_qin = 4 copies of wdata[7:0].
- Half: ram_we = 0011 (off 0) or 1100 (off 2); ram_qin = 2 copies of wdata[15:0].
- Word: ram_we = 1111; ram_qin = wdata.
- Loads drive ram_we = 0000.
- ram_addr = c_addr[AWIDTH+1:2].

Misalignment and illegal sizes:
- Misaligned: half with off[0] = 1, or word with off != 0.
- For a misaligned request: c_gnt = 1 and c_misalign = 1 in the same cycle; ram_we = 0000; no c_rvalid follows.
- Size 11 is treated as misaligned.

Debug access:
- ram_addr = d_addr, ram_we = d_we, ram_qin = d_wdata, passed through unmodified.

Read tracking FSM, next state registered at posedge:
- States: IDLE, RD_CORE, RD_DBG.
- A granted read (core load that is not misaligned, or debug with d_we = 0) moves to RD_CORE or RD_DBG. Otherwise the FSM moves to IDLE.
- In RD_CORE, the FSM latches off, size and uns. Output c_rdata = (ram_qout >> 8*off), sign/zero-extended from bit 7 or 15 per the latched size.
- RD_x to RD_y back-to-back is allowed, giving one read per cycle.

Idle RAM drive: when nothing is granted, ram_we = 0000 and ram_addr holds its last value; it is don't-care but must not write.

## Timing
- Grant and RAM drive are combinational in request cycle T.
- Read data: c_rvalid or d_rvalid is a one-cycle pulse in T+1, with data valid only while the pulse is high.
- Stores complete at the posedge ending T. No response is returned for a store.
- A read and a write to the same word in consecutive cycles: the read in T+1 returns the stored data. A same-cycle conflict is impossible because there is one grant per cycle.
- Reset values: state = IDLE, starve_cnt = 0, c_rvalid = 0, d_rvalid = 0. c_gnt, d_gnt, c_misalign and ram_we are 0 while rst is high. rdata outputs are 0.
- Reset asserted while a read is pending: the pending rvalid is suppressed.
- The requester holds req until it sees gnt. Address and data are sampled only in the grant cycle.

## Structure
- core_general.vh: AWIDTH, DWIDTH, and size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
- FSM state encodings are local to dmem_arbiter.
- Sub-module dmem_lane_align, purely combinational:
  - store side: size, off, wdata → we and qin;
  - load side: qout, off, size, uns → rdata.
- dmem_arbiter contains the arbitration, starvation counter and FSM, and instantiates dmem_lane_align.

## Test plan
- Core store byte 0xA5 at byte address 0x0003, then load byte signed from the same address → ram_we = 1000, ram_qin = A5A5A5A5; next-cycle c_rdata = 0xFFFFFFA5 with c_rvalid pulsed once.
- Core store half 0x8001 at 0x0006, then load half unsigned → ram_we = 1100; c_rdata = 0x00008001.
- Core half access at 0x0005 and word access at 0x0002 → c_gnt = 1, c_misalign = 1, ram_we = 0000, no c_rvalid.
- c_req and d_req held high together for 12 cycles with STARVE_MAX = 4 → grant pattern C,C,C,C,D repeating; starve_cnt never exceeds 4.
- Debug write d_we = 0101, data 0x11223344 over an existing word 0xAABBCCDD, then debug read → d_rdata = 0xAA22CC44.
- Core load granted, rst asserted in the following cycle → no c_rvalid; all outputs at reset values; the first access after reset is granted normally.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, access-size encodings and load context for the data-RAM arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned AWIDTH = 10;
  localparam int unsigned DWIDTH = 32;
  localparam int unsigned NLANES = DWIDTH / 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  // Load alignment context carried from the grant cycle to the data cycle.
  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
  } ld_ctx_t;

  // Size 11 has no defined lane pattern, so it is rejected like a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store size/offset to lane enables and replicated data,
// and raw RAM word to aligned, extended load data.
module dmem_lane_align
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0]        st_size,
  input  logic [1:0]        st_off,
  input  logic [DWIDTH-1:0] st_wdata,
  output logic [NLANES-1:0] we_c,
  output logic [DWIDTH-1:0] qin_c,
  input  logic [DWIDTH-1:0] ld_qout,
  input  logic [1:0]        ld_off,
  input  logic [1:0]        ld_size,
  input  logic              ld_uns,
  output logic [DWIDTH-1:0] rdata_c
);

  logic [DWIDTH-1:0] shifted;

  always_comb begin
    we_c  = '0;
    qin_c = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        we_c  = 4'(4'b0001 << st_off);
        qin_c = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        we_c  = st_off[1] ? 4'b1100 : 4'b0011;
        qin_c = {2{st_wdata[15:0]}};
      end
      SZ_WORD: we_c = 4'b1111;
      default: we_c = '0;
    endcase
  end

  always_comb begin
    shifted = ld_qout >> {ld_off, 3'b000};
    case (ld_size)
      SZ_BYTE: rdata_c = {{24{~ld_uns & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_c = {{16{~ld_uns & shifted[15]}}, shifted[15:0]};
      default: rdata_c = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data RAM: core load/store path and
// debug/loader port, with starvation relief and one-cycle read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_wr,
  input  logic [AWIDTH+1:0] c_addr,
  input  logic [1:0]        c_size,
  input  logic              c_uns,
  input  logic [DWIDTH-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_misalign,
  output logic              c_rvalid,
  output logic [DWIDTH-1:0] c_rdata,
  input  logic              d_req,
  input  logic [NLANES-1:0] d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DWIDTH-1:0] d_rdata,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_qin,
  output logic [NLANES-1:0] ram_we,
  input  logic [DWIDTH-1:0] ram_qout
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_CORE = 2'b01,
    RD_DBG  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_e            state;
  logic [CNT_W-1:0]  starve_cnt;
  ld_ctx_t           ctx;
  logic [AWIDTH-1:0] addr_q;

  logic [1:0]        off;
  logic              mis;
  logic              c_rd;
  logic              d_rd;
  logic [NLANES-1:0] st_we;
  logic [DWIDTH-1:0] st_qin;
  logic [DWIDTH-1:0] ld_rdata;

  assign off  = c_addr[1:0];
  assign mis  = misaligned(c_size, off);
  assign c_rd = c_gnt & ~c_wr & ~mis;
  assign d_rd = d_gnt & (d_we == '0);

  dmem_lane_align u_lane (
    .st_size  (c_size),
    .st_off   (off),
    .st_wdata (c_wdata),
    .we_c     (st_we),
    .qin_c    (st_qin),
    .ld_qout  (ram_qout),
    .ld_off   (ctx.off),
    .ld_size  (ctx.size),
    .ld_uns   (ctx.uns),
    .rdata_c  (ld_rdata)
  );

  // Core has priority until debug has lost STARVE_MAX contested cycles in a row.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (c_req && (!d_req || starve_cnt != STARVE_LIM)) c_gnt = 1'b1;
      else if (d_req)                                    d_gnt = 1'b1;
    end
    c_misalign = c_gnt & mis;
  end

  // RAM drive; address holds while idle so the RAM pins stay quiet.
  always_comb begin
    ram_we   = '0;
    ram_qin  = d_wdata;
    ram_addr = addr_q;
    if (c_gnt) begin
      ram_addr = c_addr[AWIDTH+1:2];
      ram_qin  = st_qin;
      if (c_wr && !mis) ram_we = st_we;
    end else if (d_gnt) begin
      ram_addr = d_addr;
      ram_qin  = d_wdata;
      ram_we   = d_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ctx        <= '0;
      addr_q     <= '0;
    end else begin
      addr_q <= ram_addr;
      if (c_rd) begin
        state <= RD_CORE;
        ctx   <= '{off: off, size: c_size, uns: c_uns};
      end else if (d_rd) begin
        state <= RD_DBG;
      end else begin
        state <= IDLE;
      end
      if (d_gnt || !d_req) starve_cnt <= '0;
      else if (c_gnt)      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Read return is gated by rst so a read pending across reset never completes.
  assign c_rvalid = (state == RD_CORE) & ~rst;
  assign d_rvalid = (state == RD_DBG) & ~rst;
  assign c_rdata  = c_rvalid ? ld_rdata : '0;
  assign d_rdata  = d_rvalid ? ram_qout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a byte-enabled read-first RAM model
// and a scoreboard of expected read returns.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              c_req, c_wr, c_uns;
  logic [AWIDTH+1:0] c_addr;
  logic [1:0]        c_size;
  logic [31:0]       c_wdata;
  logic              c_gnt, c_misalign, c_rvalid;
  logic [31:0]       c_rdata;
  logic              d_req;
  logic [3:0]        d_we;
  logic [AWIDTH-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt, d_rvalid;
  logic [31:0]       d_rdata;
  logic [AWIDTH-1:0] ram_addr;
  logic [31:0]       ram_qin;
  logic [3:0]        ram_we;
  logic [31:0]       ram_qout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_size(c_size), .c_uns(c_uns),
    .c_wdata(c_wdata), .c_gnt(c_gnt), .c_misalign(c_misalign), .c_rvalid(c_rvalid),
    .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_qin(ram_qin), .ram_we(ram_we), .ram_qout(ram_qout)
  );

  // Registered, read-first RAM with byte strobes.
  logic [31:0] mem [0:(1<<AWIDTH)-1];
  initial for (int i = 0; i < (1 << AWIDTH); i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    ram_qout <= mem[ram_addr];
    for (int i = 0; i < 4; i++)
      if (ram_we[i] === 1'b1) mem[ram_addr][8*i +: 8] <= ram_qin[8*i +: 8];
  end

  typedef struct {
    logic              rst;
    logic              c_req;
    logic              c_wr;
    logic [AWIDTH+1:0] c_addr;
    logic [1:0]        c_size;
    logic              c_uns;
    logic [31:0]       c_wdata;
    logic              d_req;
    logic [3:0]        d_we;
    logic [AWIDTH-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              e_cg;
    logic              e_dg;
    logic              e_mis;
    logic [3:0]        e_we;
    logic [AWIDTH-1:0] e_addr;
    logic [31:0]       e_qin;
    int                e_rd;     // 0 none, 1 core, 2 debug
    logic [31:0]       e_rdata;
  } vec_t;

  typedef struct {
    int          who;
    logic [31:0] data;
  } exp_t;

  exp_t pend_q[$];

  function automatic vec_t blank();
    vec_t v;
    v = '{rst: 1'b0, c_req: 1'b0, c_wr: 1'b0, c_addr: '0, c_size: 2'b00, c_uns: 1'b0,
          c_wdata: 32'h0, d_req: 1'b0, d_we: 4'h0, d_addr: '0, d_wdata: 32'h0,
          e_cg: 1'b0, e_dg: 1'b0, e_mis: 1'b0, e_we: 4'h0, e_addr: '0, e_qin: 32'h0,
          e_rd: 0, e_rdata: 32'h0};
    return v;
  endfunction

  function automatic vec_t rstv();
    vec_t v = blank();
    v.rst = 1'b1; v.c_req = 1'b1; v.d_req = 1'b1;
    return v;
  endfunction

  function automatic vec_t cv(logic wr, logic [AWIDTH+1:0] a, logic [1:0] sz, logic uns,
                              logic [31:0] wd, logic mis, logic [3:0] we, logic [31:0] qin,
                              logic [31:0] rd);
    vec_t v = blank();
    v.c_req = 1'b1; v.c_wr = wr; v.c_addr = a; v.c_size = sz; v.c_uns = uns; v.c_wdata = wd;
    v.e_cg = 1'b1; v.e_mis = mis; v.e_we = we; v.e_qin = qin;
    v.e_addr = a[AWIDTH+1:2];
    v.e_rd = (wr || mis) ? 0 : 1;
    v.e_rdata = rd;
    return v;
  endfunction

  function automatic vec_t dv(logic [3:0] we, logic [AWIDTH-1:0] a, logic [31:0] wd,
                              logic [31:0] rd);
    vec_t v = blank();
    v.d_req = 1'b1; v.d_we = we; v.d_addr = a; v.d_wdata = wd;
    v.e_dg = 1'b1; v.e_we = we; v.e_qin = wd; v.e_addr = a;
    v.e_rd = (we == 4'h0) ? 2 : 0;
    v.e_rdata = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  // Compare the response owed for the read granted in the previous cycle.
  task automatic check_resp(input int idx, input logic in_rst);
    bit          ec = 1'b0;
    bit          ed = 1'b0;
    logic [31:0] edata = 32'h0;
    exp_t        e;
    if (pend_q.size() > 0) begin
      e = pend_q.pop_front();
      ec = (e.who == 1);
      ed = (e.who == 2);
      edata = e.data;
    end
    chk("c_rvalid", idx, 32'(c_rvalid), 32'(ec));
    chk("d_rvalid", idx, 32'(d_rvalid), 32'(ed));
    if (ec) chk("c_rdata", idx, c_rdata, edata);
    if (ed) chk("d_rdata", idx, d_rdata, edata);
    if (in_rst) begin
      chk("c_rdata_rst", idx, c_rdata, 32'h0);
      chk("d_rdata_rst", idx, d_rdata, 32'h0);
    end
  endtask

  int step_no = 0;

  task automatic step(input vec_t v);
    @(negedge clk);
    rst = v.rst; c_req = v.c_req; c_wr = v.c_wr; c_addr = v.c_addr; c_size = v.c_size;
    c_uns = v.c_uns; c_wdata = v.c_wdata; d_req = v.d_req; d_we = v.d_we;
    d_addr = v.d_addr; d_wdata = v.d_wdata;
    #1;
    if (v.rst) pend_q.delete();
    check_resp(step_no, v.rst);
    chk("c_gnt", step_no, 32'(c_gnt), 32'(v.e_cg));
    chk("d_gnt", step_no, 32'(d_gnt), 32'(v.e_dg));
    chk("c_misalign", step_no, 32'(c_misalign), 32'(v.e_mis));
    chk("ram_we", step_no, 32'(ram_we), 32'(v.e_we));
    if (v.e_cg || v.e_dg) chk("ram_addr", step_no, 32'(ram_addr), 32'(v.e_addr));
    if (v.e_we != 4'h0)   chk("ram_qin", step_no, ram_qin, v.e_qin);
    if (v.e_rd != 0) pend_q.push_back('{who: v.e_rd, data: v.e_rdata});
    step_no++;
  endtask

  vec_t tbl[$];
  vec_t v;
  bit   patt [12] = '{1,1,1,1,0,1,1,1,1,0,1,1};

  initial begin
    rst = 1'b1; c_req = 1'b0; c_wr = 1'b0; c_addr = '0; c_size = 2'b00; c_uns = 1'b0;
    c_wdata = 32'h0; d_req = 1'b0; d_we = 4'h0; d_addr = '0; d_wdata = 32'h0;

    tbl.push_back(rstv());
    tbl.push_back(rstv());
    tbl.push_back(cv(1, 12'h003, SZ_BYTE, 0, 32'h000000A5, 0, 4'b1000, 32'hA5A5A5A5, 32'h0));
    tbl.push_back(cv(0, 12'h003, SZ_BYTE, 0, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFFFFA5));
    tbl.push_back(cv(0, 12'h003, SZ_BYTE, 1, 32'h0, 0, 4'b0000, 32'h0, 32'h000000A5));
    tbl.push_back(cv(1, 12'h006, SZ_HALF, 0, 32'h00008001, 0, 4'b1100, 32'h80018001, 32'h0));
    tbl.push_back(cv(0, 12'h006, SZ_HALF, 1, 32'h0, 0, 4'b0000, 32'h0, 32'h00008001));
    tbl.push_back(cv(0, 12'h006, SZ_HALF, 0, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFF8001));
    tbl.push_back(cv(0, 12'h006, SZ_BYTE, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h00000001));
    tbl.push_back(cv(1, 12'h005, SZ_HALF, 0, 32'h0000BEEF, 1, 4'b0000, 32'h0, 32'h0));
    tbl.push_back(cv(0, 12'h002, SZ_WORD, 0, 32'h0, 1, 4'b0000, 32'h0, 32'h0));
    tbl.push_back(cv(1, 12'h000, SZ_BAD, 0, 32'h12345678, 1, 4'b0000, 32'h0, 32'h0));
    tbl.push_back(dv(4'b1111, 10'd5, 32'hAABBCCDD, 32'h0));
    tbl.push_back(dv(4'b0101, 10'd5, 32'h11223344, 32'h0));
    tbl.push_back(dv(4'b0000, 10'd5, 32'h0, 32'hAA22CC44));
    tbl.push_back(cv(1, 12'h010, SZ_WORD, 0, 32'h12345678, 0, 4'b1111, 32'h12345678, 32'h0));
    tbl.push_back(cv(0, 12'h010, SZ_WORD, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h12345678));
    tbl.push_back(cv(0, 12'h011, SZ_BYTE, 1, 32'h0, 0, 4'b0000, 32'h0, 32'h00000056));
    tbl.push_back(cv(0, 12'h012, SZ_HALF, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h00001234));
    tbl.push_back(dv(4'b0000, 10'd4, 32'h0, 32'h12345678));
    tbl.push_back(cv(1, 12'h000, SZ_BYTE, 0, 32'h00000077, 0, 4'b0001, 32'h77777777, 32'h0));
    tbl.push_back(cv(0, 12'h000, SZ_WORD, 0, 32'h0, 0, 4'b0000, 32'h0, 32'hA5000077));
    tbl.push_back(blank());

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Both ports requesting continuously: debug gets every fifth slot.
    for (int i = 0; i < 12; i++) begin
      v = cv(0, 12'h010, SZ_WORD, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h12345678);
      v.d_req = 1'b1; v.d_we = 4'h0; v.d_addr = 10'd5;
      if (!patt[i]) begin
        v.e_cg = 1'b0; v.e_dg = 1'b1; v.e_addr = 10'd5;
        v.e_rd = 2; v.e_rdata = 32'hAA22CC44;
      end
      step(v);
    end
    step(blank());

    // Reset arriving while a core load is pending.
    step(cv(0, 12'h010, SZ_WORD, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h12345678));
    step(rstv());
    step(rstv());
    step(cv(0, 12'h011, SZ_BYTE, 1, 32'h0, 0, 4'b0000, 32'h0, 32'h00000056));
    step(dv(4'b0000, 10'd5, 32'h0, 32'hAA22CC44));
    step(blank());
    step(blank());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
